// File: rtl/i3c_bus_condition_monitor_if.sv
// Bus-side signal bundle of the I3C bus condition monitor: synchronized lines,
// quiet-time thresholds, condition pulses and timed bus-state flags.
interface i3c_bus_condition_monitor_if #(
  parameter int CNTR_W = 20
);
  logic              scl_i;
  logic              sda_i;
  logic [CNTR_W-1:0] t_free_i;
  logic [CNTR_W-1:0] t_avail_i;
  logic [CNTR_W-1:0] t_idle_i;
  logic              start_det_o;
  logic              rstart_det_o;
  logic              stop_det_o;
  logic              bus_busy_o;
  logic              bus_free_o;
  logic              bus_avail_o;
  logic              bus_idle_o;

  modport master (
    output scl_i, sda_i, t_free_i, t_avail_i, t_idle_i,
    input  start_det_o, rstart_det_o, stop_det_o,
    input  bus_busy_o, bus_free_o, bus_avail_o, bus_idle_o
  );

  modport slave (
    input  scl_i, sda_i, t_free_i, t_avail_i, t_idle_i,
    output start_det_o, rstart_det_o, stop_det_o,
    output bus_busy_o, bus_free_o, bus_avail_o, bus_idle_o
  );
endinterface

// File: rtl/i3c_bus_condition_monitor.sv
// Detects START / repeated START / STOP on synchronized SCL/SDA and times the
// post-STOP quiet period to raise the bus free / available / idle flags.
module i3c_bus_condition_monitor #(
  parameter int CNTR_W = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  i3c_bus_condition_monitor_if.slave bus
);

  typedef enum logic {
    QUIET = 1'b0,
    BUSY  = 1'b1
  } state_t;

  localparam logic [CNTR_W-1:0] CNT_ONE = {{(CNTR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNTR_W-1:0] r_count;
  logic [CNTR_W-1:0] w_count_nxt;
  logic              r_scl_q;
  logic              r_sda_q;
  logic              r_start_p1;
  logic              r_rstart_p1;
  logic              r_stop_p1;
  logic              w_start_nxt;
  logic              w_rstart_nxt;
  logic              w_stop_nxt;
  logic              w_start_c;
  logic              w_stop_c;
  logic              w_sclfall_c;
  logic              w_quiet_high;

  // Quiet-time counter sticks at all-ones so long idle periods never re-arm low.
  function automatic logic [CNTR_W-1:0] sat_inc(input logic [CNTR_W-1:0] v);
    logic [CNTR_W-1:0] res;
    if (&v) begin
      res = v;
    end else begin
      res = v + CNT_ONE;
    end
    return res;
  endfunction

  // Stage p0: condition decode from previous and current line samples
  assign w_start_c   = r_scl_q & bus.scl_i & r_sda_q & ~bus.sda_i;
  assign w_stop_c    = r_scl_q & bus.scl_i & ~r_sda_q & bus.sda_i;
  assign w_sclfall_c = r_scl_q & ~bus.scl_i;

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_start_nxt  = 1'b0;
    w_rstart_nxt = 1'b0;
    w_stop_nxt   = 1'b0;
    if (!enable_i) begin
      w_state_nxt = QUIET;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        QUIET: begin
          if (w_start_c) begin
            w_state_nxt = BUSY;
            w_start_nxt = 1'b1;
            w_count_nxt = '0;
          end else if (w_sclfall_c) begin
            // SCL dropping without a START is an abnormal bus-low event.
            w_state_nxt = BUSY;
            w_count_nxt = '0;
          end else if (r_scl_q && r_sda_q) begin
            w_count_nxt = sat_inc(r_count);
          end else begin
            w_count_nxt = '0;
          end
        end
        BUSY: begin
          if (w_stop_c) begin
            w_state_nxt = QUIET;
            w_stop_nxt  = 1'b1;
            w_count_nxt = '0;
          end else if (w_start_c) begin
            w_rstart_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = QUIET;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // Stage p1: registered samples, state, counter and condition pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scl_q     <= 1'b0;
      r_sda_q     <= 1'b0;
      r_state     <= QUIET;
      r_count     <= '0;
      r_start_p1  <= 1'b0;
      r_rstart_p1 <= 1'b0;
      r_stop_p1   <= 1'b0;
    end else begin
      r_scl_q     <= bus.scl_i;
      r_sda_q     <= bus.sda_i;
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_start_p1  <= w_start_nxt;
      r_rstart_p1 <= w_rstart_nxt;
      r_stop_p1   <= w_stop_nxt;
    end
  end

  assign w_quiet_high = enable_i & (r_state == QUIET) & r_scl_q & r_sda_q;

  assign bus.start_det_o  = enable_i & r_start_p1;
  assign bus.rstart_det_o = enable_i & r_rstart_p1;
  assign bus.stop_det_o   = enable_i & r_stop_p1;
  assign bus.bus_busy_o   = enable_i & (r_state == BUSY);
  assign bus.bus_free_o   = w_quiet_high & (r_count >= bus.t_free_i);
  assign bus.bus_avail_o  = w_quiet_high & (r_count >= bus.t_avail_i);
  assign bus.bus_idle_o   = w_quiet_high & (r_count >= bus.t_idle_i);

endmodule
